// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with registered single-cycle ops and iterative mul/div into Hi/Lo
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW:0] ITERS = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] LAST = (SHW+1)'(1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [SHW:0] cnt;
  logic is_div, neg_q, neg_r;
  logic [WIDTH-1:0] m, r, q, rn, qn, alu_res, a_mag, b_mag, hi_f, lo_f, sp_lo, sp_hi;
  logic [WIDTH:0] sum, t, diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic accept, multi, a_neg, b_neg, special, ge;
  logic [SHW-1:0] sh;
  assign sh = A[SHW-1:0];
  assign multi = &ALUop[3:2];
  assign a_neg = ALUop[0] & A[WIDTH-1];
  assign b_neg = ALUop[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign special = multi & ALUop[1] & ((B == '0) | (ALUop[0] & (A == MIN) & (&B)));
  assign sp_lo = (B == '0) ? '1 : A;
  assign sp_hi = (B == '0) ? A : '0;
  assign accept = InValid & InReady;
  always_comb begin
    alu_res = '0;
    case (ALUop)
      4'd0: alu_res = A + B;
      4'd1: alu_res = A - B;
      4'd2: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'd3: alu_res = {{(WIDTH-1){1'b0}}, A < B};
      4'd4: alu_res = A & B;
      4'd5: alu_res = A | B;
      4'd6: alu_res = A ^ B;
      4'd7: alu_res = ~(A | B);
      4'd8: alu_res = B << sh;
      4'd9: alu_res = B >> sh;
      4'd10: alu_res = $signed(B) >>> sh;
      4'd11: alu_res = B << (WIDTH/2);
      default: alu_res = '0;
    endcase
  end
  // one datapath step: shift-add for multiply, restoring subtract for divide
  assign sum = {1'b0, r} + (q[0] ? {1'b0, m} : '0);
  assign t = {r, q[WIDTH-1]};
  assign diff = t - {1'b0, m};
  assign ge = ~diff[WIDTH];
  assign rn = is_div ? (ge ? diff[WIDTH-1:0] : t[WIDTH-1:0]) : sum[WIDTH:1];
  assign qn = is_div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
  assign prod = {rn, qn};
  assign prod_s = neg_q ? -prod : prod;
  assign hi_f = is_div ? (neg_r ? -rn : rn) : prod_s[2*WIDTH-1:WIDTH];
  assign lo_f = is_div ? (neg_q ? -qn : qn) : prod_s[WIDTH-1:0];
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    InReady = ~Reset & ((state == IDLE) | ((state == DONE) & OutReady));
    OutValid = state == DONE;
    state_n = state;
    if (InValid & InReady) state_n = (multi & ~special) ? BUSY : DONE;
    else if (state == BUSY) state_n = (cnt == LAST) ? DONE : BUSY;
    else if ((state == DONE) & OutReady) state_n = IDLE;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      m <= '0;
      r <= '0;
      q <= '0;
      Out <= '0;
      Hi <= '0;
      Lo <= '0;
    end else if (accept) begin
      cnt <= ITERS;
      is_div <= ALUop[1];
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      m <= ALUop[1] ? b_mag : a_mag;
      q <= ALUop[1] ? a_mag : b_mag;
      r <= '0;
      if (!multi) Out <= alu_res;
      else if (special) begin
        Out <= sp_lo;
        Lo <= sp_lo;
        Hi <= sp_hi;
      end
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      r <= rn;
      q <= qn;
      if (cnt == LAST) begin
        Out <= lo_f;
        Hi <= hi_f;
        Lo <= lo_f;
      end
    end
endmodule
